// File: rtl/load_store_unit.sv
// Load/store unit: turns execute-stage byte/half/word requests into cycles on a
// word-addressed, async-read data memory, with read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);
    localparam logic [1:0]  SZ_BYTE   = 2'b00;
    localparam logic [1:0]  SZ_HALF   = 2'b01;
    localparam logic [1:0]  SZ_WORD   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_READ,
        STORE,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic        err_q;
    logic        accept;
    logic        req_err;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    assign accept = req_valid && req_ready;

    assign req_err = (req_size == 2'b11)
                   || ((req_size == SZ_HALF) && req_addr[0])
                   || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                   || ({2'b00, req_addr[31:2]} >= MEM_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (!req_write) begin
                        state_next = LOAD;
                    end else if (req_size == SZ_WORD) begin
                        state_next = STORE;
                    end else begin
                        state_next = RMW_READ;
                    end
                end
            end
            LOAD:     state_next = RESP;
            RMW_READ: state_next = STORE;
            STORE:    state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Lane extraction and sub-word merge both work on the async read word.
    always_comb begin
        lane_b    = mem_read_data[8*addr_q[1:0] +: 8];
        lane_h    = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        load_val  = mem_read_data;
        merge_val = mem_read_data;
        unique case (size_q)
            SZ_BYTE: load_val = {{24{~unsigned_q & lane_b[7]}}, lane_b};
            SZ_HALF: load_val = {{16{~unsigned_q & lane_h[15]}}, lane_h};
            default: load_val = mem_read_data;
        endcase
        if (size_q == SZ_BYTE) begin
            merge_val[8*addr_q[1:0] +: 8] = wdata_q[7:0];
        end else if (addr_q[1]) begin
            merge_val[31:16] = wdata_q[15:0];
        end else begin
            merge_val[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            merge_q    <= '0;
            err_q      <= 1'b0;
            resp_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q     <= req_addr;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        wdata_q    <= req_wdata;
                        err_q      <= req_err;
                        if (req_err) begin
                            resp_rdata <= '0;
                        end
                    end
                end
                LOAD:     resp_rdata <= load_val;
                RMW_READ: merge_q    <= merge_val;
                STORE:    resp_rdata <= '0;
                default: ;
            endcase
        end
    end

    assign resp_valid       = (state == RESP);
    assign resp_error       = resp_valid && err_q;
    assign mem_addr         = {addr_q[31:2], 2'b00};
    assign mem_write_data   = (size_q == SZ_WORD) ? wdata_q : merge_q;
    assign mem_write_enable = (state == STORE) && !reset;

endmodule
